// File: rtl/neuron_8s.sv
// 8-synapse leaky integrate-and-fire neuron: synchronised event capture, decaying
// synaptic traces, a leaky membrane and a 1-cycle spike with membrane clear.
module neuron_8s #(
    parameter int p_width     = 8,
    parameter int p_resbit    = 10,
    parameter int p_spike_num = 2,
    parameter int p_syn_shift = 4,
    parameter int p_mem_shift = 6,
    localparam int W = p_width + p_resbit + p_spike_num + 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [8:1]         i_event,
    input  logic [p_width-1:0] i_weight_1,
    input  logic [p_width-1:0] i_weight_2,
    input  logic [p_width-1:0] i_weight_3,
    input  logic [p_width-1:0] i_weight_4,
    input  logic [p_width-1:0] i_weight_5,
    input  logic [p_width-1:0] i_weight_6,
    input  logic [p_width-1:0] i_weight_7,
    input  logic [p_width-1:0] i_weight_8,
    input  logic [W-1:0]       i_threshold,
    output logic [8:1]         o_syncout,
    output logic [W-1:0]       o_sv,
    output logic [W-1:0]       o_neuron_out,
    output logic               o_spike
);

    typedef logic [W:0]   ext_t;
    typedef logic [W+2:0] sum_t;

    logic [8:1]         a_q, a_d, b_q, b_d, c_q, c_d;
    logic [W-1:0]       syn_q [1:8];
    logic [W-1:0]       syn_d [1:8];
    logic [W-1:0]       sv_q, sv_d, v_q, v_d;
    logic               spike_q, spike_d;
    logic [p_width-1:0] weight [1:8];
    logic [8:1]         pulse;
    sum_t               sum;
    ext_t               vtmp;
    logic [W-1:0]       vn;

    // Decrement of at least 1 while nonzero so a decaying value always reaches 0.
    function automatic logic [W-1:0] decay(input logic [W-1:0] val, input int shift);
        logic [W-1:0] d;
        d = val >> shift;
        if (d == '0 && val != '0) d = W'(1);
        return d;
    endfunction

    function automatic logic [W-1:0] sat(input ext_t val);
        return val[W] ? {W{1'b1}} : val[W-1:0];
    endfunction

    always_comb begin
        weight[1] = i_weight_1;
        weight[2] = i_weight_2;
        weight[3] = i_weight_3;
        weight[4] = i_weight_4;
        weight[5] = i_weight_5;
        weight[6] = i_weight_6;
        weight[7] = i_weight_7;
        weight[8] = i_weight_8;

        a_d   = i_event;
        b_d   = a_q;
        c_d   = b_q;
        pulse = b_q & ~c_q;

        sum = '0;
        for (int k = 1; k <= 8; k++) begin
            ext_t add;
            add = '0;
            if (pulse[k]) add = ext_t'(weight[k]) << p_resbit;
            syn_d[k] = sat(ext_t'(syn_q[k]) - ext_t'(decay(syn_q[k], p_syn_shift)) + add);
            sum = sum + sum_t'(syn_q[k]);
        end
        sv_d = (sum[W+2:W] != 3'b000) ? {W{1'b1}} : sum[W-1:0];

        vtmp = ext_t'(v_q) - ext_t'(decay(v_q, p_mem_shift)) + ext_t'(sv_q >> p_syn_shift);
        vn   = sat(vtmp);
        if (vn >= i_threshold) begin
            v_d     = '0;
            spike_d = 1'b1;
        end else begin
            v_d     = vn;
            spike_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            sv_q    <= '0;
            v_q     <= '0;
            spike_q <= 1'b0;
            for (int k = 1; k <= 8; k++) syn_q[k] <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sv_q    <= sv_d;
            v_q     <= v_d;
            spike_q <= spike_d;
            for (int k = 1; k <= 8; k++) syn_q[k] <= syn_d[k];
        end
    end

    assign o_syncout    = pulse;
    assign o_sv         = sv_q;
    assign o_neuron_out = v_q;
    assign o_spike      = spike_q;

endmodule

// File: tb/tb_neuron_8s.sv
// Directed bench for neuron_8s with hand-computed expected values.
module tb_neuron_8s;
    localparam int W = 23;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [8:1]   i_event = '0;
    logic [7:0]   w1 = '0, w2 = '0, w3 = '0, w4 = '0, w5 = '0, w6 = '0, w7 = '0, w8 = '0;
    logic [W-1:0] i_threshold = '0;
    logic [8:1]   o_syncout;
    logic [W-1:0] o_sv, o_neuron_out;
    logic         o_spike;

    int nvec = 0;
    int nmis = 0;

    neuron_8s dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_event(i_event),
        .i_weight_1(w1), .i_weight_2(w2), .i_weight_3(w3), .i_weight_4(w4),
        .i_weight_5(w5), .i_weight_6(w6), .i_weight_7(w7), .i_weight_8(w8),
        .i_threshold(i_threshold), .o_syncout(o_syncout), .o_sv(o_sv),
        .o_neuron_out(o_neuron_out), .o_spike(o_spike)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input logic [7:0] v);
        w1 = v; w2 = v; w3 = v; w4 = v; w5 = v; w6 = v; w7 = v; w8 = v;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_event = '0;
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        int nz, pulses, spikes, bad;
        logic [8:1]   pval;
        logic [W-1:0] prev, maxsv;

        // 1: reset held 5 cycles with all events high
        i_event = 8'hFF;
        i_rst = 1'b1;
        nz = 0;
        repeat (5) begin
            tick();
            if (o_syncout != 0 || o_sv != 0 || o_neuron_out != 0 || o_spike != 0) nz++;
        end
        chk("reset_outputs_zero", nz, 0);
        chk("reset_syncout", o_syncout, 0);

        // threshold 0 fires every cycle
        i_event = '0;
        i_threshold = '0;
        i_rst = 1'b0;
        tick();
        chk("thr0_spike_1", o_spike, 1);
        tick();
        chk("thr0_spike_2", o_spike, 1);
        chk("thr0_v", o_neuron_out, 0);

        // 2: weights FF, events 0x55 for one cycle
        do_reset();
        set_w(8'hFF);
        i_threshold = 23'h3FF;
        i_event = 8'h55;
        tick();
        chk("t2_sync_early", o_syncout, 0);
        i_event = '0;
        tick();
        chk("t2_sync_pulse", o_syncout, 8'h55);
        tick();
        chk("t2_sync_gone", o_syncout, 0);
        chk("t2_sv_lag", o_sv, 0);
        tick();
        chk("t2_sv_peak", o_sv, 23'hFF000);
        chk("t2_spike_pre", o_spike, 0);
        tick();
        chk("t2_spike", o_spike, 1);
        chk("t2_sv_decay1", o_sv, 23'hEF100);
        chk("t2_v_cleared", o_neuron_out, 0);
        tick();
        chk("t2_v_next", o_neuron_out, 0);

        // 4: decay to exactly zero, then membrane drains with no spikes
        prev = o_sv;
        bad = 0;
        for (int i = 0; i < 1000 && o_sv != 0; i++) begin
            tick();
            if (o_sv != 0 && !(o_sv < prev)) bad++;
            prev = o_sv;
        end
        chk("t4_sv_strict_decrease", bad, 0);
        chk("t4_sv_zero", o_sv, 0);
        spikes = 0;
        for (int i = 0; i < 1000 && o_neuron_out != 0; i++) begin
            tick();
            if (o_spike) spikes++;
        end
        chk("t4_v_zero", o_neuron_out, 0);
        chk("t4_no_spike", spikes, 0);

        // 3: zero weights, held level gives a single pulse and no integration
        do_reset();
        set_w(8'h00);
        i_threshold = 23'h3FF;
        i_event = 8'hFF;
        pulses = 0;
        pval = '0;
        nz = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) i_event = '0;
            tick();
            if (o_syncout != 0) begin pulses++; pval = o_syncout; end
            if (o_sv != 0 || o_neuron_out != 0 || o_spike != 0) nz++;
        end
        chk("t3_one_pulse", pulses, 1);
        chk("t3_pulse_val", pval, 8'hFF);
        chk("t3_no_activity", nz, 0);

        // single synapse, weight 1: trace and membrane values step by step
        do_reset();
        set_w(8'h00);
        w3 = 8'h01;
        i_threshold = 23'h7FFFFF;
        i_event = 8'h04;
        tick();
        i_event = '0;
        tick();
        chk("w1_pulse", o_syncout, 8'h04);
        tick();
        tick();
        chk("w1_sv0", o_sv, 23'h400);
        chk("w1_v0", o_neuron_out, 0);
        tick();
        chk("w1_sv1", o_sv, 23'h3C0);
        chk("w1_v1", o_neuron_out, 23'h40);
        tick();
        chk("w1_sv2", o_sv, 23'h384);
        chk("w1_v2", o_neuron_out, 23'h7B);

        // 5: saturation under sustained bursts
        do_reset();
        set_w(8'hFF);
        i_threshold = 23'h7FFFFF;
        maxsv = '0;
        spikes = 0;
        for (int i = 0; i < 200; i++) begin
            i_event = ((i / 2) % 2 == 0) ? 8'hFF : 8'h00;
            tick();
            if (o_sv > maxsv) maxsv = o_sv;
            if (o_spike) spikes++;
        end
        chk("t5_sv_clamp", maxsv, 23'h7FFFFF);
        chk("t5_v_clamp_fires", (spikes > 0) ? 1 : 0, 1);
        chk("t5_sv_nonzero", (o_sv != 0) ? 1 : 0, 1);

        // 6: reset mid-operation, then a fresh pulse needs low-then-high
        i_event = 8'hFF;
        i_rst = 1'b1;
        tick();
        chk("t6_sv", o_sv, 0);
        chk("t6_v", o_neuron_out, 0);
        chk("t6_spike", o_spike, 0);
        chk("t6_sync", o_syncout, 0);
        tick();
        chk("t6_sync_held", o_syncout, 0);
        i_event = '0;
        i_rst = 1'b0;
        tick();
        tick();
        chk("t6_sync_low", o_syncout, 0);
        i_event = 8'hFF;
        tick();
        tick();
        chk("t6_fresh_pulse", o_syncout, 8'hFF);
        tick();
        chk("t6_pulse_once", o_syncout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
